clock_sequencer: RTL and testbench
==================================

CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

Interface
REQ-001 Parameter INPUT_CLOCK_FREQUENCY_MHZ, default 50: clk_in frequency.
REQ-002 Parameter OUTPUT_CLOCK_FREQUENCY_KHZ, default 1: clk_out frequency.
REQ-003 Parameter MICRO_PHASES, default 10: microcode phases per clk_out cycle; even and >=2.
REQ-004 Parameter COUNT_WIDTH, default 8: width of burst_count and cycles_remaining.
REQ-005 Derived values SHALL be DIVIDER = MHZ*1000/KHZ and MICRO_DIVIDER = DIVIDER/MICRO_PHASES; elaboration SHALL fail unless DIVIDER % MICRO_PHASES == 0 and MICRO_DIVIDER is even and >=2.
REQ-006 Ports (name, direction, width, meaning):
- clk_in  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- stop  in  1  level; halt at the next cycle boundary.
- mode  in  2  00 free run, 01 single step, 10 burst, 11 treated as 01.
- step  in  1  level; rising edge requests a step or burst.
- burst_count  in  COUNT_WIDTH  cycles per burst, sampled on a step edge.
- clk_out  out  1  generated machine clock.
- microcode_clock  out  1  MICRO_PHASES pulses per clk_out cycle.
- phase  out  clog2(MICRO_PHASES)  current microcode phase.
- cycle_start  out  1  one-clk_in pulse on the first clk_in of each cycle.
- cycle_end  out  1  one-clk_in pulse on the last clk_in of each cycle.
- running  out  1  high while not IDLE.
- cycles_remaining  out  COUNT_WIDTH  cycles left in STEP state, including the current one.

Function
REQ-007 The FSM SHALL have three states: IDLE, RUN (free running) and STEP (counted).
REQ-008 The step edge SHALL be step & ~step_prev, with step_prev registered each clk_in; edges seen outside IDLE SHALL be discarded.
REQ-009 From IDLE with stop=0, the block SHALL leave IDLE as follows:
- mode 00: go to RUN.
- mode 01/11 with step edge: go to STEP with cycles_remaining=1.
- mode 10 with step edge and burst_count!=0: go to STEP with cycles_remaining=burst_count.
- mode 10 with burst_count==0: stay in IDLE.
REQ-010 Start latency SHALL be one clk_in: on the clk_in after the start condition, sub=0, phase=0, and clk_out, microcode_clock and cycle_start are high.
REQ-011 The sub counter SHALL count 0..MICRO_DIVIDER-1; phase SHALL increment when sub wraps, and phase SHALL wrap from MICRO_PHASES-1 to 0.
REQ-012 The cycle boundary SHALL be sub==MICRO_DIVIDER-1 and phase==MICRO_PHASES-1; cycle_end SHALL be high on exactly that clk_in.
REQ-013 Outputs while active SHALL be registered and glitch-free:
- clk_out = (phase < MICRO_PHASES/2).
- microcode_clock = (sub < MICRO_DIVIDER/2).
REQ-014 In IDLE, clk_out, microcode_clock, phase, cycle_start and cycle_end SHALL be 0, and the microcode clock SHALL NOT free-run.
REQ-015 At a boundary in RUN: if stop=1 or mode!=00, go to IDLE; otherwise start the next cycle back-to-back, with no gap clk_in and cycle_start on the following clk_in.
REQ-016 At a boundary in STEP: decrement cycles_remaining; if it was 1 or stop=1, go to IDLE with cycles_remaining=0; otherwise continue back-to-back.
REQ-017 Assertion of stop mid-cycle SHALL NOT truncate the cycle (no runt pulse); the current cycle SHALL complete in full.
REQ-018 Changes to mode or burst_count mid-cycle SHALL take effect only at a boundary.
REQ-019 If stop and a step edge coincide in IDLE, stop SHALL win and the edge SHALL be discarded.

Reset
REQ-020 When reset=1 at a clk_in edge, the block SHALL be forced to IDLE immediately, including mid-cycle:
- All outputs = 0.
- sub=0, phase=0, cycles_remaining=0.
- step_prev = current step, so a held-high step is not taken as an edge after reset.
REQ-021 Reset SHALL take priority over every other input.

Verification
Bench parameters: MHZ=4, KHZ=100, MICRO_PHASES=4, giving DIVIDER=40 and MICRO_DIVIDER=10.
REQ-022 Free run: mode=00, stop=0 after reset -> clk_out high for 20 and low for 20 clk_in, repeating; microcode_clock shows 5 high / 5 low, four per cycle; cycle_start every 40 clk_in.
REQ-023 Single step: mode=01, one step pulse -> exactly one 40-clk_in cycle and one cycle_end, then running=0; a second pulse given mid-cycle is ignored.
REQ-024 Burst: mode=10, burst_count=3, step edge -> 120 contiguous clk_in active; cycles_remaining reads 3, 2, 1, then 0 in IDLE. With burst_count=0 the block stays in IDLE.
REQ-025 Stop mid-cycle: in RUN, assert stop at phase 1 -> the cycle completes at 40 clk_in, then IDLE with clk_out=0. Stop during a burst of 5 in its second cycle -> exactly 2 cycles.
REQ-026 Reset mid-cycle at phase 2: all outputs are 0 on the next clk_in. With step held high through reset, no cycle starts until step falls and rises again.

Source files
------------

// File: rtl/clock_sequencer.sv
// Machine clock sequencer: divides clk_in into clk_out cycles of MICRO_PHASES
// microcode phases, with free-run, single-step and counted-burst operation.
module clock_sequencer #(
  parameter int INPUT_CLOCK_FREQUENCY_MHZ  = 50,
  parameter int OUTPUT_CLOCK_FREQUENCY_KHZ = 1,
  parameter int MICRO_PHASES               = 10,
  parameter int COUNT_WIDTH                = 8
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            stop,
  input  logic [1:0]                      mode,
  input  logic                            step,
  input  logic [COUNT_WIDTH-1:0]          burst_count,
  output logic                            clk_out,
  output logic                            microcode_clock,
  output logic [$clog2(MICRO_PHASES)-1:0] phase,
  output logic                            cycle_start,
  output logic                            cycle_end,
  output logic                            running,
  output logic [COUNT_WIDTH-1:0]          cycles_remaining
);

  localparam int DIVIDER       = INPUT_CLOCK_FREQUENCY_MHZ * 1000 / OUTPUT_CLOCK_FREQUENCY_KHZ;
  localparam int MICRO_DIVIDER = DIVIDER / MICRO_PHASES;
  localparam int SUB_W         = $clog2(MICRO_DIVIDER);
  localparam int PHASE_W       = $clog2(MICRO_PHASES);

  localparam logic [SUB_W-1:0]       SUB_LAST   = SUB_W'(MICRO_DIVIDER - 1);
  localparam logic [SUB_W-1:0]       SUB_HALF   = SUB_W'(MICRO_DIVIDER / 2);
  localparam logic [SUB_W-1:0]       SUB_ONE    = SUB_W'(1);
  localparam logic [PHASE_W-1:0]     PHASE_LAST = PHASE_W'(MICRO_PHASES - 1);
  localparam logic [PHASE_W-1:0]     PHASE_HALF = PHASE_W'(MICRO_PHASES / 2);
  localparam logic [PHASE_W-1:0]     PHASE_ONE  = PHASE_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  if ((MICRO_PHASES < 2) || (MICRO_PHASES % 2 != 0) || (DIVIDER % MICRO_PHASES != 0) ||
      (MICRO_DIVIDER < 2) || (MICRO_DIVIDER % 2 != 0)) begin : g_bad_params
    $error("clock_sequencer: clock ratio does not split into even microcode phases");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t                   state_r, state_n;
  logic [SUB_W-1:0]         sub_r, sub_n;
  logic [PHASE_W-1:0]       phase_r, phase_n;
  logic [COUNT_WIDTH-1:0]   cycles_r, cycles_n;
  logic                     step_prev_r;
  logic                     step_edge_s;
  logic                     boundary_s;
  logic                     active_s;
  logic                     clk_out_r, micro_r, cycle_start_r, cycle_end_r, running_r;

  assign step_edge_s = step & ~step_prev_r;
  assign boundary_s  = (sub_r == SUB_LAST) && (phase_r == PHASE_LAST);
  assign active_s    = (state_n != ST_IDLE);

  // Next-state, counter advance and cycle-boundary decisions
  always_comb begin
    state_n  = state_r;
    sub_n    = sub_r;
    phase_n  = phase_r;
    cycles_n = cycles_r;
    case (state_r)
      ST_IDLE: begin
        sub_n    = '0;
        phase_n  = '0;
        cycles_n = '0;
        if (stop) begin
          state_n = ST_IDLE;
        end else if (mode == 2'b00) begin
          state_n = ST_RUN;
        end else if (mode == 2'b10) begin
          if (step_edge_s && (burst_count != '0)) begin
            state_n  = ST_STEP;
            cycles_n = burst_count;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (step_edge_s) begin
          state_n  = ST_STEP;
          cycles_n = CNT_ONE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (boundary_s) begin
          sub_n   = '0;
          phase_n = '0;
          if (state_r == ST_RUN) begin
            if (stop || (mode != 2'b00)) begin
              state_n = ST_IDLE;
            end else begin
              state_n = ST_RUN;
            end
          end else if (stop || (cycles_r <= CNT_ONE)) begin
            state_n  = ST_IDLE;
            cycles_n = '0;
          end else begin
            cycles_n = cycles_r - CNT_ONE;
          end
        end else if (sub_r == SUB_LAST) begin
          sub_n   = '0;
          phase_n = phase_r + PHASE_ONE;
        end else begin
          sub_n = sub_r + SUB_ONE;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        sub_n    = '0;
        phase_n  = '0;
        cycles_n = '0;
      end
    endcase
  end

  // State, counters and outputs; every output comes straight from a flop
  always_ff @(posedge clk_in) begin
    step_prev_r <= step;
    if (reset) begin
      state_r       <= ST_IDLE;
      sub_r         <= '0;
      phase_r       <= '0;
      cycles_r      <= '0;
      clk_out_r     <= 1'b0;
      micro_r       <= 1'b0;
      cycle_start_r <= 1'b0;
      cycle_end_r   <= 1'b0;
      running_r     <= 1'b0;
    end else begin
      state_r       <= state_n;
      sub_r         <= sub_n;
      phase_r       <= phase_n;
      cycles_r      <= cycles_n;
      clk_out_r     <= active_s && (phase_n < PHASE_HALF);
      micro_r       <= active_s && (sub_n < SUB_HALF);
      cycle_start_r <= active_s && (sub_n == '0) && (phase_n == '0);
      cycle_end_r   <= active_s && (sub_n == SUB_LAST) && (phase_n == PHASE_LAST);
      running_r     <= active_s;
    end
  end

  assign clk_out          = clk_out_r;
  assign microcode_clock  = micro_r;
  assign phase            = phase_r;
  assign cycle_start      = cycle_start_r;
  assign cycle_end        = cycle_end_r;
  assign running          = running_r;
  assign cycles_remaining = cycles_r;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer at 4 MHz -> 100 kHz with 4 phases
// (40 clk_in per cycle, 10 clk_in per microcode phase).
module tb_clock_sequencer;

  logic       clk_in = 1'b0;
  logic       reset, stop, step;
  logic [1:0] mode;
  logic [7:0] burst_count;
  logic       clk_out, microcode_clock, cycle_start, cycle_end, running;
  logic [1:0] phase;
  logic [7:0] cycles_remaining;

  int checks = 0;
  int errors = 0;

  clock_sequencer #(
    .INPUT_CLOCK_FREQUENCY_MHZ(4),
    .OUTPUT_CLOCK_FREQUENCY_KHZ(100),
    .MICRO_PHASES(4),
    .COUNT_WIDTH(8)
  ) dut (
    .clk_in(clk_in), .reset(reset), .stop(stop), .mode(mode), .step(step),
    .burst_count(burst_count), .clk_out(clk_out), .microcode_clock(microcode_clock),
    .phase(phase), .cycle_start(cycle_start), .cycle_end(cycle_end),
    .running(running), .cycles_remaining(cycles_remaining)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       rst, stp;
    logic [1:0] md;
    logic       st;
    logic [7:0] bc;
    int         n;
    logic       e_clk, e_mc;
    logic [1:0] e_ph;
    logic       e_cs, e_ce, e_run;
    logic [7:0] e_cr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [1:0] m, input logic st,
                     input logic [7:0] b, input int n, input logic ck, input logic mc,
                     input logic [1:0] ph, input logic cs, input logic ce,
                     input logic run, input logic [7:0] cr);
    vec_t v;
    v.rst = r; v.stp = s; v.md = m; v.st = st; v.bc = b; v.n = n;
    v.e_clk = ck; v.e_mc = mc; v.e_ph = ph; v.e_cs = cs; v.e_ce = ce; v.e_run = run; v.e_cr = cr;
    vecs.push_back(v);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int hi, falls, rises, cs_n, ce_n, run_n;
  logic prev_mc, prev_clk;

  initial begin
    reset = 1'b1; stop = 1'b0; step = 1'b0; mode = 2'b00; burst_count = 8'd0;

    //   rst   stop  mode   step  burst n    clk   mc    ph    cs    ce    run   cr
    add(1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // free run
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 4,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 4,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 10, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 19, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    // stop raised at phase 1 lets the cycle finish
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 10, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 28, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // single step, second pulse mid-cycle ignored
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 2,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b1, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 15, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b01, 1'b1, 8'd0, 1,  1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 23, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 5,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // burst of 3; burst_count change mid-burst has no effect
    add(1'b0, 1'b0, 2'b10, 1'b1, 8'd3, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd3);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd7, 39, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd3);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd7, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd2);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd7, 40, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd7, 39, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd7, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // burst of 0 stays idle
    add(1'b0, 1'b0, 2'b10, 1'b1, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd0, 3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // burst of 5 stopped during its second cycle
    add(1'b0, 1'b0, 2'b10, 1'b1, 8'd5, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd5);
    add(1'b0, 1'b0, 2'b10, 1'b0, 8'd5, 40, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd4);
    add(1'b0, 1'b1, 2'b10, 1'b0, 8'd5, 5,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd4);
    add(1'b0, 1'b1, 2'b10, 1'b0, 8'd5, 34, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd4);
    add(1'b0, 1'b1, 2'b10, 1'b0, 8'd5, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // stop beats a coincident step edge; the edge is not remembered
    add(1'b0, 1'b1, 2'b01, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b1, 2'b01, 1'b1, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b1, 8'd0, 3,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // reset at phase 2, step held high through reset
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 20, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b1, 1'b0, 2'b01, 1'b1, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b1, 8'd0, 5,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b1, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b1, 1'b0, 2'b01, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // mode 11 acts as single step
    add(1'b0, 1'b0, 2'b11, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 2'b11, 1'b1, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b11, 1'b0, 8'd0, 39, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd1);
    add(1'b0, 1'b0, 2'b11, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    // mode leaves 00 mid-cycle: takes effect only at the boundary
    add(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 1,  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 10, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 29, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'd0);
    add(1'b0, 1'b0, 2'b01, 1'b0, 8'd0, 1,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; stop = vecs[i].stp; mode = vecs[i].md;
      step = vecs[i].st; burst_count = vecs[i].bc;
      repeat (vecs[i].n) @(posedge clk_in);
      #1;
      checks++;
      if ({clk_out, microcode_clock, phase, cycle_start, cycle_end, running, cycles_remaining} !==
          {vecs[i].e_clk, vecs[i].e_mc, vecs[i].e_ph, vecs[i].e_cs, vecs[i].e_ce,
           vecs[i].e_run, vecs[i].e_cr}) begin
        errors++;
        $display("FAIL vec%0d: got clk=%b mc=%b ph=%0d cs=%b ce=%b run=%b cr=%0d, expected clk=%b mc=%b ph=%0d cs=%b ce=%b run=%b cr=%0d",
                 i, clk_out, microcode_clock, phase, cycle_start, cycle_end, running, cycles_remaining,
                 vecs[i].e_clk, vecs[i].e_mc, vecs[i].e_ph, vecs[i].e_cs, vecs[i].e_ce,
                 vecs[i].e_run, vecs[i].e_cr);
      end
    end

    // Free-run waveform statistics over two full cycles
    reset = 1'b1; stop = 1'b0; step = 1'b0; mode = 2'b00; burst_count = 8'd0;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(posedge clk_in); #1;
    hi = 0; falls = 0; rises = 0; cs_n = 0; ce_n = 0; run_n = 0;
    prev_mc = 1'b0; prev_clk = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (clk_out) hi++;
      if (!clk_out && prev_clk) falls++;
      if (microcode_clock && !prev_mc) rises++;
      prev_mc = microcode_clock; prev_clk = clk_out;
      cs_n += int'(cycle_start); ce_n += int'(cycle_end); run_n += int'(running);
      @(posedge clk_in); #1;
    end
    check_int("fr_clk_high", hi, 40);
    check_int("fr_clk_falls", falls, 2);
    check_int("fr_micro_pulses", rises, 8);
    check_int("fr_cycle_starts", cs_n, 2);
    check_int("fr_cycle_ends", ce_n, 2);
    check_int("fr_running", run_n, 80);

    // Burst of 3 must be 120 contiguous active clk_in
    reset = 1'b1; mode = 2'b10; burst_count = 8'd3;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(posedge clk_in); #1;
    step = 1'b1;
    run_n = 0; ce_n = 0; cs_n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_in); #1;
      step = 1'b0;
      run_n += int'(running); ce_n += int'(cycle_end); cs_n += int'(cycle_start);
    end
    check_int("burst_active", run_n, 120);
    check_int("burst_ends", ce_n, 3);
    check_int("burst_starts", cs_n, 3);
    check_int("burst_final_cr", int'(cycles_remaining), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
